// File: rtl/sha256_msg_padder_pkg.sv
// rtl/sha256_msg_padder_pkg.sv - shared states and constants for the SHA-256 message padder
package sha256_msg_padder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PAD    = 3'd2,
    ST_ROUNDS = 3'd3,
    ST_EXTRA  = 3'd4
  } state_e;

  localparam int          ROUND_CNT     = 64;
  localparam int          WORDS_PER_BLK = 16;
  localparam logic [7:0]  PAD_BYTE      = 8'h80;
  localparam logic [31:0] PAD_WORD      = {PAD_BYTE, 24'h000000};
  localparam int          LEN_HI_IDX    = 14;
  localparam int          LEN_LO_IDX    = 15;

endpackage

// File: rtl/sha_pad_word.sv
// rtl/sha_pad_word.sv - keeps the first nbytes of a big-endian word, inserts 0x80 after them
module sha_pad_word
  import sha256_msg_padder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_nbytes,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < i_nbytes) begin
        o_word[31-8*b -: 8] = i_word[31-8*b -: 8];
      end else if (3'(b) == i_nbytes) begin
        o_word[31-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 padding front end feeding the message schedule
module sha256_msg_padder
  import sha256_msg_padder_pkg::*;
#(
  parameter int MSG_SIZ = 512,
  parameter int MSG_BLK = 32,
  parameter int BLK_CNT = 6,
  parameter int LEN_W   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [MSG_BLK-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_last,
  input  logic [2:0]         i_nbytes,
  output logic               o_ready,
  output logic [MSG_SIZ-1:0] o_msg,
  output logic               o_msg_schdl_en,
  output logic [BLK_CNT-1:0] o_blk_nmbr,
  output logic               o_blk_first,
  output logic               o_blk_final,
  output logic               o_done,
  output logic               o_busy
);

  state_e             state_q, state_d;
  logic [MSG_BLK-1:0] buf_q [WORDS_PER_BLK];
  logic [MSG_BLK-1:0] buf_d [WORDS_PER_BLK];
  logic [3:0]         wp_q, wp_d;
  logic [4:0]         p_q, p_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pad_pend_q, pad_pend_d;
  logic               p80_pend_q, p80_pend_d;
  logic               final_q, final_d;
  logic               first_q, first_d;
  logic [BLK_CNT-1:0] rnd_q, rnd_d;
  logic               done_q, done_d;
  logic [MSG_BLK-1:0] pad_word;

  sha_pad_word u_pad_word (
    .i_word   (i_data),
    .i_nbytes (i_nbytes),
    .o_word   (pad_word)
  );

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wp_d       = wp_q;
    p_d        = p_q;
    len_d      = len_q;
    pad_pend_d = pad_pend_q;
    p80_pend_d = p80_pend_q;
    final_d    = final_q;
    first_d    = first_q;
    rnd_d      = rnd_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          wp_d       = '0;
          p_d        = '0;
          len_d      = '0;
          pad_pend_d = 1'b0;
          p80_pend_d = 1'b0;
          final_d    = 1'b0;
          first_d    = 1'b1;
          for (int i = 0; i < WORDS_PER_BLK; i++) buf_d[i] = '0;
        end
      end

      ST_LOAD: begin
        if (i_valid) begin
          buf_d[wp_q] = pad_word;
          len_d       = len_q + LEN_W'({i_nbytes, 3'b000});
          if (!i_last) begin
            // A full non-final block streams straight back into LOAD after its rounds.
            if (wp_q == 4'd15) begin
              state_d    = ST_ROUNDS;
              pad_pend_d = 1'b0;
              p80_pend_d = 1'b0;
            end else begin
              wp_d = wp_q + 4'd1;
            end
          end else if (i_nbytes < 3'd4) begin
            p_d     = {1'b0, wp_q};
            state_d = ST_PAD;
          end else begin
            p_d = {1'b0, wp_q} + 5'd1;
            if (wp_q == 4'd15) begin
              p80_pend_d = 1'b1;
              pad_pend_d = 1'b1;
              state_d    = ST_ROUNDS;
            end else begin
              buf_d[wp_q + 4'd1] = PAD_WORD;
              state_d            = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        for (int i = 0; i < WORDS_PER_BLK; i++) begin
          if (5'(i) > p_q) buf_d[i] = '0;
        end
        // The length needs words 14/15 free; otherwise it goes into an extra block.
        if (p_q <= 5'd13) begin
          buf_d[LEN_HI_IDX] = len_q[LEN_W-1 -: 32];
          buf_d[LEN_LO_IDX] = len_q[31:0];
          final_d           = 1'b1;
        end else begin
          pad_pend_d = 1'b1;
        end
        state_d = ST_ROUNDS;
      end

      ST_ROUNDS: begin
        first_d = 1'b0;
        if (rnd_q == BLK_CNT'(ROUND_CNT - 1)) begin
          rnd_d = '0;
          if (final_q) begin
            done_d  = 1'b1;
            final_d = 1'b0;
            state_d = ST_IDLE;
          end else if (pad_pend_q) begin
            state_d = ST_EXTRA;
          end else begin
            for (int i = 0; i < WORDS_PER_BLK; i++) buf_d[i] = '0;
            wp_d    = '0;
            state_d = ST_LOAD;
          end
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end

      ST_EXTRA: begin
        for (int i = 0; i < WORDS_PER_BLK; i++) buf_d[i] = '0;
        if (p80_pend_q) buf_d[0] = PAD_WORD;
        buf_d[LEN_HI_IDX] = len_q[LEN_W-1 -: 32];
        buf_d[LEN_LO_IDX] = len_q[31:0];
        final_d           = 1'b1;
        pad_pend_d        = 1'b0;
        p80_pend_d        = 1'b0;
        state_d           = ST_ROUNDS;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < WORDS_PER_BLK; i++) buf_q[i] <= '0;
      wp_q       <= '0;
      p_q        <= '0;
      len_q      <= '0;
      pad_pend_q <= 1'b0;
      p80_pend_q <= 1'b0;
      final_q    <= 1'b0;
      first_q    <= 1'b0;
      rnd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < WORDS_PER_BLK; i++) buf_q[i] <= buf_d[i];
      wp_q       <= wp_d;
      p_q        <= p_d;
      len_q      <= len_d;
      pad_pend_q <= pad_pend_d;
      p80_pend_q <= p80_pend_d;
      final_q    <= final_d;
      first_q    <= first_d;
      rnd_q      <= rnd_d;
      done_q     <= done_d;
    end
  end

  for (genvar g = 0; g < WORDS_PER_BLK; g++) begin : g_msg
    assign o_msg[MSG_SIZ-1-MSG_BLK*g -: MSG_BLK] = buf_q[g];
  end

  assign o_ready        = (state_q == ST_LOAD);
  assign o_msg_schdl_en = (state_q == ST_ROUNDS);
  assign o_blk_nmbr     = rnd_q;
  assign o_blk_first    = (state_q == ST_ROUNDS) && first_q && (rnd_q == '0);
  assign o_blk_final    = (state_q == ST_ROUNDS) && final_q;
  assign o_done         = done_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule
